regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single write port of register_file between two writeback sources:
//   ALU results and memory-load results. Each source uses a valid/ready handshake.
//   Round-robin arbitration applies when both sources request in the same cycle.
//   The granted write goes through one output register stage, then drives write_reg/dst_reg/dst_data.
//   Also reports a hazard mask and a saturating conflict counter for stall logic and debug.
// PARAMETERS
//   ADDR_W   4    register index width (16 architectural registers)
//   DATA_W   16   register data width
//   CNT_W    8    conflict counter width
// PORTS
//   clk            in   1       single clock, all state updates on posedge
//   rst            in   1       synchronous, active-high reset
//   alu_valid      in   1       ALU writeback request
//   alu_ready      out  1       ALU request accepted this cycle
//   alu_dst        in   ADDR_W  ALU destination register
//   alu_data       in   DATA_W  ALU result
//   mem_valid      in   1       load writeback request
//   mem_ready      out  1       load request accepted this cycle
//   mem_dst        in   ADDR_W  load destination register
//   mem_data       in   DATA_W  load data
//   write_reg      out  1       to register_file write enable
//   dst_reg        out  ADDR_W  to register_file write address
//   dst_data       out  DATA_W  to register_file write data
//   pending_mask   out  2**ADDR_W  one bit per register with a write not yet committed
//   conflict_cnt   out  CNT_W   count of cycles in which both sources were valid
// BEHAVIOUR
//   - Reset (rst=1 at posedge): write_reg=0, dst_reg=0, dst_data=0, conflict_cnt=0.
//     The priority pointer is set to ALU. Any in-flight request is dropped and is not committed.
//     alu_ready=mem_ready=0 while rst=1.
//   - Handshake: a transfer occurs when valid&&ready at a posedge. A source must hold
//     valid/dst/data stable until it is accepted. ready may depend combinationally on valid.
//   - Grant (combinational): only one valid -> that source is ready.
//     Both valid -> the source named by the priority pointer is ready; the other sees ready=0.
//   - Pointer: after any accept, it points to the source that was NOT granted.
//     It is unchanged in cycles with no accept. At most one accept per cycle.
//   - Latency: accept at edge N -> write_reg=1 with dst_reg/dst_data during cycle N+1.
//     register_file stores the value at edge N+1. No accept -> write_reg=0.
//     dst_reg/dst_data hold their last values.
//   - Throughput: one write per cycle sustained. Back-to-back accepts from the
//     same source are allowed when the other source is idle.
//   - Same destination from both sources in one cycle: the granted source commits first.
//     The other commits in a later cycle, so its value is the final one.
//     No merging or dropping of writes.
//   - pending_mask (combinational) is the OR of:
//       decode(dst_reg) when write_reg=1;
//       decode(alu_dst) when alu_valid=1;
//       decode(mem_dst) when mem_valid=1.
//     It is all-zeros in reset.
//   - conflict_cnt: +1 at each posedge with alu_valid&&mem_valid. It saturates at all-ones
//     and never wraps.
//   - Register index 0 is an ordinary writable register. No special-casing.
// STRUCTURE
//   - Shared package regfile_pkg: ADDR_W, DATA_W, NUM_REGS, and the enum wb_src_e {SRC_ALU, SRC_MEM}
//     for the pointer.
//   - Sub-module rr_arbiter2: 2-way round-robin grant with a pointer register.
//     It is reusable for the read-port sharing planned next.
//   - The top level holds the output register stage, the pending_mask decode and the counter.
// TESTING
//   1. Reset: hold rst for 2 cycles with both valids=1.
//      -> ready=0 on both, write_reg=0, pending_mask=0, conflict_cnt=0.
//   2. Lone ALU: alu_valid, dst=3, data=16'h0011 -> alu_ready the same cycle.
//      Next cycle write_reg=1, dst_reg=3, dst_data=16'h0011. Reading reg 3 afterwards returns 16'h0011.
//   3. Conflict: both valid for 3 cycles. ALU has dst=5, data=16'h00AA; MEM has dst=6, data=16'h00BB.
//      -> ALU granted first, then MEM. Writes commit in that order.
//      conflict_cnt=1 after the first cycle.
//   4. Same dst: both target reg 9. ALU data=16'h1111, MEM data=16'h2222.
//      -> two writes, ALU then MEM. Reg 9 finally reads 16'h2222.
//   5. Saturation: 300 consecutive conflict cycles -> conflict_cnt stops at 8'hFF.
//      The grants keep alternating.
//   6. Reset mid-operation: assert rst in the cycle after an accept.
//      -> write_reg=0 next cycle and the register keeps its old value.
//      The pointer returns to ALU.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: widths and the
// writeback source encoding used by the round-robin pointer.
package regfile_pkg;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 8;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is the ALU side and req[1]/gnt[1]
// is the MEM side. The pointer names the side that wins a tie.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    wb_src_e ptr_q;
    wb_src_e ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (!rst) begin
            if (req == 2'b11)
                gnt = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
        // After an accept, the side that lost the grant wins the next tie
        if (gnt[0])
            ptr_d = SRC_MEM;
        else if (gnt[1])
            ptr_d = SRC_ALU;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= SRC_ALU;
        else
            ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with one
// output register stage, a pending-write mask and a saturating conflict counter.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int CNT_W  = regfile_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_dst,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_dst,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 write_reg,
    output logic [ADDR_W-1:0]    dst_reg,
    output logic [DATA_W-1:0]    dst_data,
    output logic [2**ADDR_W-1:0] pending_mask,
    output logic [CNT_W-1:0]     conflict_cnt
);
    logic [1:0] gnt;
    logic       wr_vld;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({mem_valid, alu_valid}),
        .gnt (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld   <= 1'b0;
            dst_reg  <= '0;
            dst_data <= '0;
        end else begin
            wr_vld <= |gnt;
            if (gnt[0]) begin
                dst_reg  <= alu_dst;
                dst_data <= alu_data;
            end else if (gnt[1]) begin
                dst_reg  <= mem_dst;
                dst_data <= mem_data;
            end
        end
    end

    // Gating with rst drops a write that is in flight when reset arrives
    assign write_reg = wr_vld & ~rst;

    always_comb begin
        pending_mask = '0;
        if (!rst) begin
            if (write_reg) pending_mask[dst_reg] = 1'b1;
            if (alu_valid) pending_mask[alu_dst] = 1'b1;
            if (mem_valid) pending_mask[mem_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (alu_valid && mem_valid && conflict_cnt != {CNT_W{1'b1}})
            conflict_cnt <= conflict_cnt + 1'b1;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a transaction-level
// model of the arbitration rules and a model register file.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_dst, mem_dst, dst_reg;
    logic [15:0] alu_data, mem_data, dst_data;
    logic        write_reg;
    logic [15:0] pending_mask;
    logic [7:0]  conflict_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
        .write_reg(write_reg), .dst_reg(dst_reg), .dst_data(dst_data),
        .pending_mask(pending_mask), .conflict_cnt(conflict_cnt)
    );

    // Register file driven by the DUT write port
    logic [15:0] tb_rf [16];
    always @(posedge clk) if (write_reg) tb_rf[dst_reg] <= dst_data;

    int n_cmp = 0, n_bad = 0;

    // Reference model state
    bit          m_prio_mem;
    bit          m_wr;
    logic [3:0]  m_dst;
    logic [15:0] m_data;
    int          m_cnt;
    logic [15:0] m_rf [16];
    bit          acc_a, acc_m;
    logic [15:0] exp_mask;

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task req_alu(input logic [3:0] d, input logic [15:0] x);
        alu_valid = 1'b1; alu_dst = d; alu_data = x;
    endtask

    task req_mem(input logic [3:0] d, input logic [15:0] x);
        mem_valid = 1'b1; mem_dst = d; mem_data = x;
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge,
    // then retire whichever request the model says was accepted.
    task step();
        @(negedge clk);
        acc_a = 1'b0; acc_m = 1'b0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                acc_a = !m_prio_mem; acc_m = m_prio_mem;
            end else begin
                acc_a = alu_valid; acc_m = mem_valid;
            end
        end
        exp_mask = '0;
        if (!rst) begin
            if (m_wr)      exp_mask = exp_mask | (16'h1 << m_dst);
            if (alu_valid) exp_mask = exp_mask | (16'h1 << alu_dst);
            if (mem_valid) exp_mask = exp_mask | (16'h1 << mem_dst);
        end
        chk("alu_ready", alu_ready, acc_a);
        chk("mem_ready", mem_ready, acc_m);
        chk("write_reg", write_reg, m_wr && !rst);
        chk("dst_reg", dst_reg, m_dst);
        chk("dst_data", dst_data, m_data);
        chk("pending_mask", pending_mask, exp_mask);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("regfile", tb_rf[m_dst], m_rf[m_dst]);
        @(posedge clk);
        if (rst) begin
            m_wr = 0; m_dst = '0; m_data = '0; m_cnt = 0; m_prio_mem = 0;
        end else begin
            if (m_wr) m_rf[m_dst] = m_data;
            if (alu_valid && mem_valid && m_cnt < 255) m_cnt++;
            if (acc_a) begin
                m_wr = 1; m_dst = alu_dst; m_data = alu_data; m_prio_mem = 1;
            end else if (acc_m) begin
                m_wr = 1; m_dst = mem_dst; m_data = mem_data; m_prio_mem = 0;
            end else begin
                m_wr = 0;
            end
        end
        #1;
        if (acc_a) alu_valid = 1'b0;
        if (acc_m) mem_valid = 1'b0;
    endtask

    task drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin tb_rf[i] = '0; m_rf[i] = '0; end
        m_prio_mem = 0; m_wr = 0; m_dst = '0; m_data = '0; m_cnt = 0;
        rst = 1'b1;
        req_alu(4'd1, 16'h1234);
        req_mem(4'd2, 16'h5678);
        @(posedge clk); #1;

        // Reset with both sources requesting
        drain(2);
        chk("t1_cnt", conflict_cnt, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b0;

        // Lone ALU write
        req_alu(4'd3, 16'h0011);
        drain(3);
        chk("t2_rf3", tb_rf[3], 16'h0011);

        // Conflict starting from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        req_alu(4'd5, 16'h00AA);
        req_mem(4'd6, 16'h00BB);
        step();
        chk("t3_cnt1", conflict_cnt, 1);
        drain(3);
        chk("t3_rf5", tb_rf[5], 16'h00AA);
        chk("t3_rf6", tb_rf[6], 16'h00BB);

        // Same destination from both sides: the later writer wins
        req_alu(4'd9, 16'h1111);
        req_mem(4'd9, 16'h2222);
        drain(4);
        chk("t4_rf9", tb_rf[9], 16'h2222);

        // Sustained conflict saturates the counter
        for (int i = 0; i < 300; i++) begin
            if (!alu_valid) req_alu(4'($urandom), 16'($urandom));
            if (!mem_valid) req_mem(4'($urandom), 16'($urandom));
            step();
        end
        chk("t5_sat", conflict_cnt, 8'hFF);
        drain(3);

        // Reset right after an accept drops the in-flight write
        alu_valid = 1'b0; mem_valid = 1'b0;
        drain(2);
        req_alu(4'd2, 16'hBEEF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rf2_kept", tb_rf[2], m_rf[2]);
        req_alu(4'd7, 16'h0707);
        req_mem(4'd8, 16'h0808);
        #1;
        chk("t6_ptr_alu", alu_ready, 1'b1);
        drain(4);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) req_alu(4'($urandom), 16'($urandom));
            if (!mem_valid && $urandom_range(0, 2) != 0) req_mem(4'($urandom), 16'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        drain(3);
        for (int i = 0; i < 16; i++) chk("final_rf", tb_rf[i], m_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
